hex_display_scan: RTL and testbench

HEX_DISPLAY_SCAN -- requirements
Module: hex_display_scan

---
 rtl/hex_display_scan.sv | 141 ++++++++++++++
 tb/tb_hex_display_scan.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// Purpose: six-digit hex to 7-segment display driver. One shared decoder is time-multiplexed over the digits, with optional leading-zero blanking and a lamp test.
// Latency: a load accepted at edge E0 updates hex5..hex0 at E1..E6. done is high in the cycle after E6.
// Backpressure: load_ready is high only in IDLE, so one load is accepted every 7 cycles at most. Inputs are ignored while a scan runs.

module hexTo7Seg (
  input  logic [3:0] hex_input,
  output logic [6:0] seven_seg_out
);

  // Active-low segment patterns, bit order gfedcba
  always_comb begin
    seven_seg_out = 7'h7F;
    case (hex_input)
      4'h0: seven_seg_out = 7'h40;
      4'h1: seven_seg_out = 7'h79;
      4'h2: seven_seg_out = 7'h24;
      4'h3: seven_seg_out = 7'h30;
      4'h4: seven_seg_out = 7'h19;
      4'h5: seven_seg_out = 7'h12;
      4'h6: seven_seg_out = 7'h02;
      4'h7: seven_seg_out = 7'h78;
      4'h8: seven_seg_out = 7'h00;
      4'h9: seven_seg_out = 7'h10;
      4'hA: seven_seg_out = 7'h08;
      4'hB: seven_seg_out = 7'h03;
      4'hC: seven_seg_out = 7'h46;
      4'hD: seven_seg_out = 7'h21;
      4'hE: seven_seg_out = 7'h06;
      4'hF: seven_seg_out = 7'h0E;
      default: seven_seg_out = 7'h7F;
    endcase
  end

endmodule

module hex_display_scan #(
  parameter logic [6:0] BLANK_CODE = 7'h7F,
  parameter logic [6:0] LAMP_CODE  = 7'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [23:0] load_data,
  input  logic        blank_lz,
  input  logic        lamp_test,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t      state_q;
  logic [2:0]  idx_q;
  logic [23:0] shadow_q;
  logic        blank_q;
  logic        seen_q;
  logic        done_q;
  logic [6:0]  hex_q [6];

  logic [3:0]  nib_d;
  logic [6:0]  seg_code;
  logic        blank_d;
  logic [6:0]  digit_d;

  // The shadow nibble at the current scan index feeds the single shared decoder
  hexTo7Seg u_dec (
    .hex_input     (nib_d),
    .seven_seg_out (seg_code)
  );

  // Pick the current nibble and decide whether it is a leading zero to blank. Digit 0 is never blanked.
  always_comb begin
    nib_d   = shadow_q[{idx_q, 2'b00} +: 4];
    blank_d = blank_q && !seen_q && (nib_d == 4'h0) && (idx_q != 3'd0);
    digit_d = blank_d ? BLANK_CODE : seg_code;
  end

  // Scan FSM: capture on accept, then write one digit per edge from MSD down to LSD
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= 3'd5;
      shadow_q <= 24'h0;
      blank_q  <= 1'b0;
      seen_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < 6; i++) hex_q[i] <= BLANK_CODE;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            shadow_q <= load_data;
            blank_q  <= blank_lz;
            idx_q    <= 3'd5;
            seen_q   <= 1'b0;
            state_q  <= SCAN;
          end
        end
        SCAN: begin
          for (int i = 0; i < 6; i++) begin
            if (idx_q == i[2:0]) hex_q[i] <= digit_d;
          end
          if (nib_d != 4'h0) seen_q <= 1'b1;
          if (idx_q == 3'd0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Lamp test overrides only the output muxes, so the stored digits remain available when it drops
  always_comb begin
    hex0 = lamp_test ? LAMP_CODE : hex_q[0];
    hex1 = lamp_test ? LAMP_CODE : hex_q[1];
    hex2 = lamp_test ? LAMP_CODE : hex_q[2];
    hex3 = lamp_test ? LAMP_CODE : hex_q[3];
    hex4 = lamp_test ? LAMP_CODE : hex_q[4];
    hex5 = lamp_test ? LAMP_CODE : hex_q[5];
  end

  // Handshake and status are decoded straight from the state register
  always_comb begin
    load_ready = (state_q == IDLE);
    busy       = (state_q == SCAN);
    done       = done_q;
  end

endmodule

// File: tb/tb_hex_display_scan.sv
// Purpose: self-checking bench for hex_display_scan. A result-level model is compared against the DUT every cycle, and directed literal checks are added on top.
// Latency: inputs are driven 1 time unit after posedge. The model is compared at every negedge.
// Backpressure: every wait on the DUT is bounded. A wait that runs out counts as a failed check.

module tb_hex_display_scan;

  logic        clk = 1'b0;
  logic        reset, load_valid, blank_lz, lamp_test;
  logic [23:0] load_data;
  logic        load_ready, busy, done;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

  int n_checks = 0;
  int n_pass   = 0;

  hex_display_scan dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .blank_lz   (blank_lz),
    .lamp_test  (lamp_test),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3),
    .hex4       (hex4),
    .hex5       (hex5),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [41:0] dut_hex();
    return {hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  // ---------------- behavioural model ----------------
  // At accept time the model works out the whole final display from the value itself. It then reveals one digit per cycle, from the MSD down.
  logic        model_ok = 1'b0;
  logic        m_busy, m_done;
  int          m_step;
  logic [6:0]  m_final [6];
  logic [6:0]  m_disp  [6];

  always @(posedge clk) begin
    if (reset) begin
      model_ok = 1'b1;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_step   = 0;
      for (int d = 0; d < 6; d++) m_disp[d] = 7'h7F;
    end else if (model_ok) begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (load_valid) begin
          for (int d = 0; d < 6; d++) begin
            if (blank_lz && d != 0 && ((load_data >> (4 * d)) == 24'h0))
              m_final[d] = 7'h7F;
            else
              m_final[d] = seg(4'((load_data >> (4 * d)) & 24'hF));
          end
          m_busy = 1'b1;
          m_step = 0;
        end
      end else begin
        m_disp[5 - m_step] = m_final[5 - m_step];
        if (m_step == 5) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else begin
          m_step++;
        end
      end
    end
  end

  // Compare the DUT against the model at every negedge once reset has been seen
  always @(negedge clk) begin
    if (model_ok) begin
      chk("cyc_hex", {22'h0, dut_hex()},
          lamp_test ? 64'h0 : {22'h0, m_disp[5], m_disp[4], m_disp[3], m_disp[2], m_disp[1], m_disp[0]});
      chk("cyc_busy",  {63'h0, busy},       {63'h0, m_busy});
      chk("cyc_ready", {63'h0, load_ready}, {63'h0, !m_busy});
      chk("cyc_done",  {63'h0, done},       {63'h0, m_done});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!load_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) chk("ready_timeout", 64'd0, 64'd1);
  endtask

  // Accept a value, scramble the inputs during the scan, and return once done is high
  task automatic load_and_wait(input logic [23:0] d, input logic b, output int busy_cyc);
    int n = 0;
    busy_cyc   = 0;
    wait_ready();
    load_data  = d;
    blank_lz   = b;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    load_data  = ~d;
    blank_lz   = ~b;
    while (!done && n < 20) begin
      if (busy) busy_cyc++;
      tick();
      load_valid = n[0];
      n++;
    end
    load_valid = 1'b0;
    if (n >= 20) chk("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int bc;
    int last;
    reset      = 1'b1;
    load_valid = 1'b1;
    load_data  = 24'h123456;
    blank_lz   = 1'b0;
    lamp_test  = 1'b0;
    tick();
    tick();
    chk("reset_hex",   {22'h0, dut_hex()}, {22'h0, {6{7'h7F}}});
    chk("reset_done",  {63'h0, done},       64'd0);
    chk("reset_ready", {63'h0, load_ready}, 64'd1);
    load_valid = 1'b0;
    reset      = 1'b0;
    tick();
    chk("post_reset_ready", {63'h0, load_ready}, 64'd1);

    // Basic scan: check latency and the six decoded digits
    load_and_wait(24'h012345, 1'b0, bc);
    chk("basic_busy_cycles", 64'(bc), 64'd6);
    chk("basic_hex", {22'h0, dut_hex()}, {22'h0, 7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12});
    chk("basic_ready_with_done", {63'h0, load_ready}, 64'd1);
    tick();
    chk("done_one_cycle", {63'h0, done}, 64'd0);

    // Leading-zero blanking
    load_and_wait(24'h00000A, 1'b1, bc);
    chk("blank_A", {22'h0, dut_hex()}, {22'h0, {5{7'h7F}}, 7'h08});
    load_and_wait(24'h000000, 1'b1, bc);
    chk("blank_zero", {22'h0, dut_hex()}, {22'h0, {5{7'h7F}}, 7'h40});
    load_and_wait(24'h00F00F, 1'b1, bc);
    chk("blank_F00F", {22'h0, dut_hex()}, {22'h0, 7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40, 7'h0E});

    // Back-to-back: hold load_valid with data changing every cycle
    wait_ready();
    last = -1;
    load_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      load_data = 24'(24'h135790 + c * 24'h0A3B1D);
      blank_lz  = c[1];
      tick();
      if (done) begin
        if (last >= 0) chk("b2b_period", 64'(c - last), 64'd7);
        last = c;
      end
    end
    load_valid = 1'b0;
    wait_ready();
    tick();

    // Reset at E3 of a scan of FFFFFF
    wait_ready();
    load_data  = 24'hFFFFFF;
    blank_lz   = 1'b0;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_hex",   {22'h0, dut_hex()}, {22'h0, {6{7'h7F}}});
    chk("rst_mid_done",  {63'h0, done},       64'd0);
    chk("rst_mid_ready", {63'h0, load_ready}, 64'd1);
    reset = 1'b0;
    tick();
    chk("rst_mid_no_done", {63'h0, done}, 64'd0);

    // Lamp test raised mid-scan
    load_data  = 24'h0ABCDE;
    blank_lz   = 1'b0;
    load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    tick();
    tick();
    lamp_test = 1'b1;
    #1;
    chk("lamp_hex", {22'h0, dut_hex()}, 64'd0);
    begin
      int n = 0;
      while (!done && n < 20) begin
        tick();
        n++;
      end
      chk("lamp_done_seen", {63'h0, done}, 64'd1);
    end
    chk("lamp_hex_at_done", {22'h0, dut_hex()}, 64'd0);
    lamp_test = 1'b0;
    #1;
    chk("lamp_release_hex", {22'h0, dut_hex()},
        {22'h0, 7'h40, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06});
    tick();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
